// File: rtl/vending_machine_gen.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_gen
// Description : Parametrised vending controller with an N_ROWS x N_COLS
//               selection grid, coin-credit accumulator, run-time
//               programmable per-item prices and per-item stock counters
//               with sold-out detection. It also provides a cancel/refund
//               path and a row-selection timeout. All outputs are registered.
// Ports       : CLK            - sole clock, rising edge
//               I_RESET        - synchronous active-high reset
//               I_COIN_VALID   - one-cycle coin strobe, value on I_COIN_VALUE
//               I_ROW / I_COL  - letter / digit buttons, lowest index wins
//               I_CANCEL       - refund request
//               I_ITEM_ADDR    - item targeted by price write / restock
//               I_PRICE_WE     - write I_PRICE_DATA into price[I_ITEM_ADDR]
//               I_RESTOCK      - reload stock[I_ITEM_ADDR] with INIT_STOCK
//               O_CREDIT       - accumulated credit
//               O_PRICE        - price of the item under evaluation
//               O_SEL          - index of the last vended item
//               O_SUCCESS      - pulse: item vended
//               O_CHANGE       - change/refund, qualified by O_CHANGE_VALID
//               O_SOLD_OUT     - pulse: selected item has zero stock
//               O_INSUFFICIENT - pulse: credit below price
//               O_COIN_RETURN  - pulse: coin rejected
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_gen #(
  parameter int N_ROWS        = 4,
  parameter int N_COLS        = 4,
  parameter int PRICE_W       = 16,
  parameter int STOCK_W       = 4,
  parameter int DEFAULT_PRICE = 100,
  parameter int INIT_STOCK    = 2,
  parameter int MAX_CREDIT    = 9999,
  parameter int TIMEOUT_CYC   = 16,
  localparam int N_ITEMS      = N_ROWS * N_COLS,
  localparam int SEL_W        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               CLK,
  input  logic               I_RESET,
  input  logic               I_COIN_VALID,
  input  logic [PRICE_W-1:0] I_COIN_VALUE,
  input  logic [N_ROWS-1:0]  I_ROW,
  input  logic [N_COLS-1:0]  I_COL,
  input  logic               I_CANCEL,
  input  logic [SEL_W-1:0]   I_ITEM_ADDR,
  input  logic               I_PRICE_WE,
  input  logic [PRICE_W-1:0] I_PRICE_DATA,
  input  logic               I_RESTOCK,
  output logic [PRICE_W-1:0] O_CREDIT,
  output logic [PRICE_W-1:0] O_PRICE,
  output logic [SEL_W-1:0]   O_SEL,
  output logic               O_SUCCESS,
  output logic [PRICE_W-1:0] O_CHANGE,
  output logic               O_CHANGE_VALID,
  output logic               O_SOLD_OUT,
  output logic               O_INSUFFICIENT,
  output logic               O_COIN_RETURN
);

  localparam int c_row_w = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int c_col_w = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int c_tmr_w = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PRICE_W:0]    c_max_sum   = (PRICE_W + 1)'(MAX_CREDIT);
  localparam logic [PRICE_W-1:0]  c_price_rst = PRICE_W'(DEFAULT_PRICE);
  localparam logic [STOCK_W-1:0]  c_stock_rst = STOCK_W'(INIT_STOCK);
  localparam logic [c_tmr_w-1:0]  c_tmo_last  = c_tmr_w'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROW    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [PRICE_W-1:0]   r_credit;
  logic [c_row_w-1:0]   r_row;
  logic [SEL_W-1:0]     r_idx;
  logic [c_tmr_w-1:0]   r_timer;
  logic [PRICE_W-1:0]   r_price_out;
  logic [SEL_W-1:0]     r_sel;
  logic [PRICE_W-1:0]   r_change;
  logic                 r_success;
  logic                 r_change_valid;
  logic                 r_sold_out;
  logic                 r_insufficient;
  logic                 r_coin_return;

  logic [PRICE_W-1:0]   r_price [N_ITEMS];
  logic [STOCK_W-1:0]   r_stock [N_ITEMS];

  // --------------------------------------------------------------------------
  // Combinational next-state values
  // --------------------------------------------------------------------------
  state_t               w_state_nxt;
  logic [PRICE_W-1:0]   w_credit_nxt;
  logic [c_row_w-1:0]   w_row_nxt;
  logic [SEL_W-1:0]     w_idx_nxt;
  logic [c_tmr_w-1:0]   w_timer_nxt;
  logic [PRICE_W-1:0]   w_price_out_nxt;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [PRICE_W-1:0]   w_change_nxt;
  logic                 w_success_nxt;
  logic                 w_change_valid_nxt;
  logic                 w_sold_out_nxt;
  logic                 w_insufficient_nxt;
  logic                 w_coin_return_nxt;

  logic                 w_row_hit;
  logic [c_row_w-1:0]   w_row_enc;
  logic                 w_col_hit;
  logic [c_col_w-1:0]   w_col_enc;
  logic [SEL_W-1:0]     w_new_idx;
  logic [PRICE_W-1:0]   w_new_price;
  logic [STOCK_W-1:0]   w_cur_stock;
  logic [PRICE_W:0]     w_coin_sum;
  logic                 w_coin_ok;
  logic                 w_cfg_en;
  logic                 w_vend_dec;

  // Button encoders: scanning from the top down leaves the lowest set bit.
  always_comb begin
    w_row_hit = |I_ROW;
    w_row_enc = '0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (I_ROW[i]) w_row_enc = c_row_w'(i);
    end
  end

  always_comb begin
    w_col_hit = |I_COL;
    w_col_enc = '0;
    for (int i = N_COLS - 1; i >= 0; i--) begin
      if (I_COL[i]) w_col_enc = c_col_w'(i);
    end
  end

  // A column press always combines with the row already latched, never with
  // a row pressed in the same cycle.
  assign w_new_idx = SEL_W'(r_row) * SEL_W'(N_COLS) + SEL_W'(w_col_enc);

  // Table lookups as explicit muxes so out-of-range indices read as zero.
  always_comb begin
    w_new_price = '0;
    w_cur_stock = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (w_new_idx == SEL_W'(i)) w_new_price = r_price[i];
      if (r_idx == SEL_W'(i))     w_cur_stock = r_stock[i];
    end
  end

  // One extra bit so the credit + coin sum cannot wrap before the ceiling test.
  assign w_coin_sum = {1'b0, r_credit} + {1'b0, I_COIN_VALUE};
  assign w_coin_ok  = ((r_state == ST_IDLE) || (r_state == ST_ROW)) &&
                      (w_coin_sum <= c_max_sum);

  assign w_cfg_en   = (r_state == ST_IDLE);
  assign w_vend_dec = (r_state == ST_VEND);

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_row_nxt          = r_row;
    w_idx_nxt          = r_idx;
    w_timer_nxt        = r_timer;
    w_price_out_nxt    = r_price_out;
    w_sel_nxt          = r_sel;
    w_change_nxt       = r_change;
    w_success_nxt      = 1'b0;
    w_change_valid_nxt = 1'b0;
    w_sold_out_nxt     = 1'b0;
    w_insufficient_nxt = 1'b0;
    w_coin_return_nxt  = 1'b0;

    if (I_COIN_VALID) begin
      if (w_coin_ok) begin
        w_credit_nxt = w_coin_sum[PRICE_W-1:0];
      end else begin
        w_coin_return_nxt = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (I_CANCEL) begin
          if (r_credit != '0) w_state_nxt = ST_CHANGE;
        end else if (w_row_hit) begin
          w_row_nxt   = w_row_enc;
          w_timer_nxt = '0;
          w_state_nxt = ST_ROW;
        end
      end

      ST_ROW: begin
        if (I_CANCEL) begin
          w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (w_col_hit) begin
          w_idx_nxt       = w_new_idx;
          w_price_out_nxt = w_new_price;
          w_state_nxt     = ST_CHECK;
        end else if (w_row_hit) begin
          w_row_nxt   = w_row_enc;
          w_timer_nxt = '0;
        end else if (r_timer == c_tmo_last) begin
          // Abandon the row but keep the credit.
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + c_tmr_w'(1);
        end
      end

      ST_CHECK: begin
        if (w_cur_stock == '0) begin
          w_sold_out_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else if (r_credit < r_price_out) begin
          w_insufficient_nxt = 1'b1;
          w_state_nxt        = ST_IDLE;
        end else begin
          w_state_nxt = ST_VEND;
        end
      end

      ST_VEND: begin
        w_sel_nxt     = r_idx;
        w_success_nxt = 1'b1;
        w_credit_nxt  = r_credit - r_price_out;
        w_state_nxt   = ST_CHANGE;
      end

      ST_CHANGE: begin
        // Issued even for zero change so the hopper always sees a completion.
        w_change_nxt       = r_credit;
        w_change_valid_nxt = 1'b1;
        w_credit_nxt       = '0;
        w_price_out_nxt    = '0;
        w_state_nxt        = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      r_credit       <= '0;
      r_row          <= '0;
      r_idx          <= '0;
      r_timer        <= '0;
      r_price_out    <= '0;
      r_sel          <= '0;
      r_change       <= '0;
      r_success      <= 1'b0;
      r_change_valid <= 1'b0;
      r_sold_out     <= 1'b0;
      r_insufficient <= 1'b0;
      r_coin_return  <= 1'b0;
    end else begin
      r_credit       <= w_credit_nxt;
      r_row          <= w_row_nxt;
      r_idx          <= w_idx_nxt;
      r_timer        <= w_timer_nxt;
      r_price_out    <= w_price_out_nxt;
      r_sel          <= w_sel_nxt;
      r_change       <= w_change_nxt;
      r_success      <= w_success_nxt;
      r_change_valid <= w_change_valid_nxt;
      r_sold_out     <= w_sold_out_nxt;
      r_insufficient <= w_insufficient_nxt;
      r_coin_return  <= w_coin_return_nxt;
    end
  end

  // Price and stock tables. Configuration only lands in IDLE; the decrement
  // only happens in VEND, so the two never collide on one item.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (I_RESET) begin
        r_price[i] <= c_price_rst;
        r_stock[i] <= c_stock_rst;
      end else begin
        if (w_cfg_en && I_PRICE_WE && (I_ITEM_ADDR == SEL_W'(i))) begin
          r_price[i] <= I_PRICE_DATA;
        end
        if (w_cfg_en && I_RESTOCK && (I_ITEM_ADDR == SEL_W'(i))) begin
          r_stock[i] <= c_stock_rst;
        end else if (w_vend_dec && (r_idx == SEL_W'(i))) begin
          r_stock[i] <= r_stock[i] - STOCK_W'(1);
        end
      end
    end
  end

  assign O_CREDIT       = r_credit;
  assign O_PRICE        = r_price_out;
  assign O_SEL          = r_sel;
  assign O_SUCCESS      = r_success;
  assign O_CHANGE       = r_change;
  assign O_CHANGE_VALID = r_change_valid;
  assign O_SOLD_OUT     = r_sold_out;
  assign O_INSUFFICIENT = r_insufficient;
  assign O_COIN_RETURN  = r_coin_return;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_machine_gen
// Description : Directed self-checking bench for vending_machine_gen with
//               default parameters (4x4 grid, price 100, stock 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_gen;

  logic        CLK = 1'b0;
  logic        I_RESET;
  logic        I_COIN_VALID;
  logic [15:0] I_COIN_VALUE;
  logic [3:0]  I_ROW;
  logic [3:0]  I_COL;
  logic        I_CANCEL;
  logic [3:0]  I_ITEM_ADDR;
  logic        I_PRICE_WE;
  logic [15:0] I_PRICE_DATA;
  logic        I_RESTOCK;
  logic [15:0] O_CREDIT;
  logic [15:0] O_PRICE;
  logic [3:0]  O_SEL;
  logic        O_SUCCESS;
  logic [15:0] O_CHANGE;
  logic        O_CHANGE_VALID;
  logic        O_SOLD_OUT;
  logic        O_INSUFFICIENT;
  logic        O_COIN_RETURN;

  int n_tests = 0;
  int n_fail  = 0;

  vending_machine_gen dut (
    .CLK            (CLK),
    .I_RESET        (I_RESET),
    .I_COIN_VALID   (I_COIN_VALID),
    .I_COIN_VALUE   (I_COIN_VALUE),
    .I_ROW          (I_ROW),
    .I_COL          (I_COL),
    .I_CANCEL       (I_CANCEL),
    .I_ITEM_ADDR    (I_ITEM_ADDR),
    .I_PRICE_WE     (I_PRICE_WE),
    .I_PRICE_DATA   (I_PRICE_DATA),
    .I_RESTOCK      (I_RESTOCK),
    .O_CREDIT       (O_CREDIT),
    .O_PRICE        (O_PRICE),
    .O_SEL          (O_SEL),
    .O_SUCCESS      (O_SUCCESS),
    .O_CHANGE       (O_CHANGE),
    .O_CHANGE_VALID (O_CHANGE_VALID),
    .O_SOLD_OUT     (O_SOLD_OUT),
    .O_INSUFFICIENT (O_INSUFFICIENT),
    .O_COIN_RETURN  (O_COIN_RETURN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one rising edge; outputs are then sampled 1ns after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic insert(input logic [15:0] v);
    I_COIN_VALID = 1'b1;
    I_COIN_VALUE = v;
    cyc();
    I_COIN_VALID = 1'b0;
  endtask

  // Row press then column press; afterwards the DUT is in CHECK.
  task automatic select_item(input logic [3:0] row, input logic [3:0] col);
    I_ROW = row;
    cyc();
    I_ROW = '0;
    I_COL = col;
    cyc();
    I_COL = '0;
  endtask

  task automatic test_reset();
    I_RESET = 1'b1;
    cyc();
    cyc();
    n_tests++; if (O_CREDIT !== 16'd0) begin n_fail++; $display("FAIL reset_credit: O_CREDIT=%0d expected 0", O_CREDIT); end
    n_tests++; if (O_PRICE !== 16'd0) begin n_fail++; $display("FAIL reset_price: O_PRICE=%0d expected 0", O_PRICE); end
    n_tests++; if ({O_SEL, O_CHANGE} !== 20'd0) begin n_fail++; $display("FAIL reset_sel_change: O_SEL=%0d O_CHANGE=%0d expected 0 0", O_SEL, O_CHANGE); end
    n_tests++; if ({O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT, O_INSUFFICIENT, O_COIN_RETURN} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses: pulses=%b expected 00000", {O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT, O_INSUFFICIENT, O_COIN_RETURN}); end
    I_RESET = 1'b0;
    cyc();
  endtask

  task automatic test_exact_credit();
    insert(16'd100);
    n_tests++; if (O_CREDIT !== 16'd100) begin n_fail++; $display("FAIL exact_coin_credit: O_CREDIT=%0d expected 100", O_CREDIT); end
    n_tests++; if (O_COIN_RETURN !== 1'b0) begin n_fail++; $display("FAIL exact_coin_accept: O_COIN_RETURN=%b expected 0", O_COIN_RETURN); end
    select_item(4'b0001, 4'b0001);
    n_tests++; if (O_PRICE !== 16'd100) begin n_fail++; $display("FAIL exact_price: O_PRICE=%0d expected 100", O_PRICE); end
    cyc();
    n_tests++; if ({O_SOLD_OUT, O_INSUFFICIENT} !== 2'b00) begin n_fail++; $display("FAIL exact_check_ok: sold_out/insuff=%b expected 00", {O_SOLD_OUT, O_INSUFFICIENT}); end
    cyc();
    n_tests++; if (O_SUCCESS !== 1'b1) begin n_fail++; $display("FAIL exact_success: O_SUCCESS=%b expected 1", O_SUCCESS); end
    n_tests++; if (O_SEL !== 4'd0) begin n_fail++; $display("FAIL exact_sel: O_SEL=%0d expected 0", O_SEL); end
    n_tests++; if (O_CREDIT !== 16'd0) begin n_fail++; $display("FAIL exact_credit_after_vend: O_CREDIT=%0d expected 0", O_CREDIT); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd0) begin n_fail++; $display("FAIL exact_change: valid=%b change=%0d expected 1 0", O_CHANGE_VALID, O_CHANGE); end
    n_tests++; if (O_SUCCESS !== 1'b0 || O_PRICE !== 16'd0) begin n_fail++; $display("FAIL exact_after_change: success=%b price=%0d expected 0 0", O_SUCCESS, O_PRICE); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b0) begin n_fail++; $display("FAIL exact_change_width: O_CHANGE_VALID=%b expected 0", O_CHANGE_VALID); end
  endtask

  task automatic test_insufficient();
    I_ITEM_ADDR  = 4'd5;
    I_PRICE_DATA = 16'd250;
    I_PRICE_WE   = 1'b1;
    cyc();
    I_PRICE_WE   = 1'b0;
    insert(16'd200);
    select_item(4'b0010, 4'b0010);
    n_tests++; if (O_PRICE !== 16'd250) begin n_fail++; $display("FAIL insuff_price: O_PRICE=%0d expected 250", O_PRICE); end
    cyc();
    n_tests++; if (O_INSUFFICIENT !== 1'b1) begin n_fail++; $display("FAIL insuff_pulse: O_INSUFFICIENT=%b expected 1", O_INSUFFICIENT); end
    n_tests++; if (O_CREDIT !== 16'd200) begin n_fail++; $display("FAIL insuff_credit_kept: O_CREDIT=%0d expected 200", O_CREDIT); end
    cyc();
    n_tests++; if (O_INSUFFICIENT !== 1'b0 || O_PRICE !== 16'd250) begin n_fail++; $display("FAIL insuff_after: insuff=%b price=%0d expected 0 250", O_INSUFFICIENT, O_PRICE); end
    insert(16'd100);
    n_tests++; if (O_CREDIT !== 16'd300) begin n_fail++; $display("FAIL topup_credit: O_CREDIT=%0d expected 300", O_CREDIT); end
    select_item(4'b0010, 4'b0010);
    cyc();
    cyc();
    n_tests++; if (O_SUCCESS !== 1'b1 || O_SEL !== 4'd5) begin n_fail++; $display("FAIL topup_vend: success=%b sel=%0d expected 1 5", O_SUCCESS, O_SEL); end
    n_tests++; if (O_CREDIT !== 16'd50) begin n_fail++; $display("FAIL topup_credit_after: O_CREDIT=%0d expected 50", O_CREDIT); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd50) begin n_fail++; $display("FAIL topup_change: valid=%b change=%0d expected 1 50", O_CHANGE_VALID, O_CHANGE); end
  endtask

  // Starts in the first IDLE cycle after the previous CHANGE.
  task automatic test_back_to_back();
    I_COIN_VALID = 1'b1;
    I_COIN_VALUE = 16'd400;
    I_ROW        = 4'b0001;
    cyc();
    I_COIN_VALID = 1'b0;
    n_tests++; if (O_CREDIT !== 16'd400) begin n_fail++; $display("FAIL b2b_credit: O_CREDIT=%0d expected 400", O_CREDIT); end
    I_ROW = 4'b0010;
    cyc();
    I_ROW = 4'b1000;
    cyc();
    I_ROW = 4'b0000;
    I_COL = 4'b1000;
    cyc();
    I_COL = 4'b0000;
    n_tests++; if (O_PRICE !== 16'd100) begin n_fail++; $display("FAIL b2b_price: O_PRICE=%0d expected 100", O_PRICE); end
    cyc();
    cyc();
    n_tests++; if (O_SUCCESS !== 1'b1 || O_SEL !== 4'd15) begin n_fail++; $display("FAIL last_letter_sel: success=%b sel=%0d expected 1 15", O_SUCCESS, O_SEL); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd300) begin n_fail++; $display("FAIL last_letter_change: valid=%b change=%0d expected 1 300", O_CHANGE_VALID, O_CHANGE); end
  endtask

  task automatic test_sold_out();
    I_ITEM_ADDR = 4'd0;
    I_RESTOCK   = 1'b1;
    cyc();
    I_RESTOCK   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      insert(16'd100);
      select_item(4'b0001, 4'b0001);
      cyc();
      cyc();
      n_tests++; if (O_SUCCESS !== 1'b1) begin n_fail++; $display("FAIL sold_out_vend%0d: O_SUCCESS=%b expected 1", k, O_SUCCESS); end
      cyc();
    end
    insert(16'd100);
    select_item(4'b0001, 4'b0001);
    cyc();
    n_tests++; if (O_SOLD_OUT !== 1'b1 || O_INSUFFICIENT !== 1'b0) begin n_fail++; $display("FAIL sold_out_pulse: sold_out=%b insuff=%b expected 1 0", O_SOLD_OUT, O_INSUFFICIENT); end
    n_tests++; if (O_CREDIT !== 16'd100) begin n_fail++; $display("FAIL sold_out_credit: O_CREDIT=%0d expected 100", O_CREDIT); end
    cyc();
    n_tests++; if (O_SOLD_OUT !== 1'b0) begin n_fail++; $display("FAIL sold_out_width: O_SOLD_OUT=%b expected 0", O_SOLD_OUT); end
    I_RESTOCK = 1'b1;
    cyc();
    I_RESTOCK = 1'b0;
    select_item(4'b0001, 4'b0001);
    cyc();
    cyc();
    n_tests++; if (O_SUCCESS !== 1'b1 || O_SEL !== 4'd0) begin n_fail++; $display("FAIL restock_vend: success=%b sel=%0d expected 1 0", O_SUCCESS, O_SEL); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd0) begin n_fail++; $display("FAIL restock_change: valid=%b change=%0d expected 1 0", O_CHANGE_VALID, O_CHANGE); end
    // A price write while in ROW must be ignored.
    I_ROW = 4'b0001;
    cyc();
    I_ROW        = 4'b0000;
    I_ITEM_ADDR  = 4'd0;
    I_PRICE_DATA = 16'd7;
    I_PRICE_WE   = 1'b1;
    cyc();
    I_PRICE_WE = 1'b0;
    I_COL      = 4'b0001;
    cyc();
    I_COL = 4'b0000;
    n_tests++; if (O_PRICE !== 16'd100) begin n_fail++; $display("FAIL price_we_in_row: O_PRICE=%0d expected 100", O_PRICE); end
    cyc();
    n_tests++; if (O_INSUFFICIENT !== 1'b1) begin n_fail++; $display("FAIL zero_credit_insuff: O_INSUFFICIENT=%b expected 1", O_INSUFFICIENT); end
  endtask

  task automatic test_cancel_coins();
    insert(16'd9990);
    insert(16'd25);
    n_tests++; if (O_COIN_RETURN !== 1'b1 || O_CREDIT !== 16'd9990) begin n_fail++; $display("FAIL overflow_coin: return=%b credit=%0d expected 1 9990", O_COIN_RETURN, O_CREDIT); end
    cyc();
    n_tests++; if (O_COIN_RETURN !== 1'b0) begin n_fail++; $display("FAIL coin_return_width: O_COIN_RETURN=%b expected 0", O_COIN_RETURN); end
    I_CANCEL = 1'b1;
    cyc();
    I_CANCEL = 1'b0;
    n_tests++; if (O_CHANGE_VALID !== 1'b0) begin n_fail++; $display("FAIL cancel_early: O_CHANGE_VALID=%b expected 0", O_CHANGE_VALID); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd9990 || O_CREDIT !== 16'd0) begin n_fail++; $display("FAIL cancel_refund: valid=%b change=%0d credit=%0d expected 1 9990 0", O_CHANGE_VALID, O_CHANGE, O_CREDIT); end
    // Cancel beats a simultaneous row press.
    insert(16'd50);
    I_CANCEL = 1'b1;
    I_ROW    = 4'b0001;
    cyc();
    I_CANCEL = 1'b0;
    I_ROW    = 4'b0000;
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd50) begin n_fail++; $display("FAIL cancel_priority: valid=%b change=%0d expected 1 50", O_CHANGE_VALID, O_CHANGE); end
    // Coin strobed while the machine is in VEND.
    insert(16'd100);
    select_item(4'b0010, 4'b0001);
    cyc();
    I_COIN_VALID = 1'b1;
    I_COIN_VALUE = 16'd50;
    cyc();
    I_COIN_VALID = 1'b0;
    n_tests++; if (O_COIN_RETURN !== 1'b1 || O_SUCCESS !== 1'b1) begin n_fail++; $display("FAIL busy_coin_return: return=%b success=%b expected 1 1", O_COIN_RETURN, O_SUCCESS); end
    n_tests++; if (O_CREDIT !== 16'd0 || O_SEL !== 4'd4) begin n_fail++; $display("FAIL busy_coin_credit: credit=%0d sel=%0d expected 0 4", O_CREDIT, O_SEL); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd0) begin n_fail++; $display("FAIL busy_coin_change: valid=%b change=%0d expected 1 0", O_CHANGE_VALID, O_CHANGE); end
    // Exactly at the credit ceiling, then one cent over.
    insert(16'd9999);
    n_tests++; if (O_COIN_RETURN !== 1'b0 || O_CREDIT !== 16'd9999) begin n_fail++; $display("FAIL ceiling_accept: return=%b credit=%0d expected 0 9999", O_COIN_RETURN, O_CREDIT); end
    insert(16'd1);
    n_tests++; if (O_COIN_RETURN !== 1'b1 || O_CREDIT !== 16'd9999) begin n_fail++; $display("FAIL ceiling_reject: return=%b credit=%0d expected 1 9999", O_COIN_RETURN, O_CREDIT); end
    I_CANCEL = 1'b1;
    cyc();
    I_CANCEL = 1'b0;
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd9999) begin n_fail++; $display("FAIL ceiling_refund: valid=%b change=%0d expected 1 9999", O_CHANGE_VALID, O_CHANGE); end
    // Cancel in IDLE with no credit does nothing.
    I_CANCEL = 1'b1;
    cyc();
    I_CANCEL = 1'b0;
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b0) begin n_fail++; $display("FAIL cancel_zero_credit: O_CHANGE_VALID=%b expected 0", O_CHANGE_VALID); end
  endtask

  task automatic test_timeout();
    // 15 idle cycles: still in ROW, the column press is taken (C3, idx 10).
    I_ROW = 4'b0100;
    cyc();
    I_ROW = 4'b0000;
    repeat (15) cyc();
    I_COL = 4'b0100;
    cyc();
    I_COL = 4'b0000;
    n_tests++; if (O_PRICE !== 16'd100) begin n_fail++; $display("FAIL timeout_edge_price: O_PRICE=%0d expected 100", O_PRICE); end
    cyc();
    n_tests++; if (O_INSUFFICIENT !== 1'b1) begin n_fail++; $display("FAIL timeout_edge_check: O_INSUFFICIENT=%b expected 1", O_INSUFFICIENT); end
    // Give C3 a distinct price so an accepted press would be visible.
    I_ITEM_ADDR  = 4'd10;
    I_PRICE_DATA = 16'd55;
    I_PRICE_WE   = 1'b1;
    cyc();
    I_PRICE_WE = 1'b0;
    insert(16'd30);
    I_ROW = 4'b0100;
    cyc();
    I_ROW = 4'b0000;
    repeat (16) cyc();
    I_COL = 4'b0100;
    cyc();
    I_COL = 4'b0000;
    n_tests++; if (O_PRICE !== 16'd100) begin n_fail++; $display("FAIL timeout_col_ignored: O_PRICE=%0d expected 100", O_PRICE); end
    cyc();
    n_tests++; if (O_INSUFFICIENT !== 1'b0 || O_CREDIT !== 16'd30) begin n_fail++; $display("FAIL timeout_credit_kept: insuff=%b credit=%0d expected 0 30", O_INSUFFICIENT, O_CREDIT); end
  endtask

  task automatic test_reset_mid();
    select_item(4'b0001, 4'b0010);
    I_RESET = 1'b1;
    cyc();
    n_tests++; if (O_CREDIT !== 16'd0 || O_PRICE !== 16'd0) begin n_fail++; $display("FAIL midreset_credit_price: credit=%0d price=%0d expected 0 0", O_CREDIT, O_PRICE); end
    n_tests++; if (O_SEL !== 4'd0 || O_CHANGE !== 16'd0) begin n_fail++; $display("FAIL midreset_sel_change: sel=%0d change=%0d expected 0 0", O_SEL, O_CHANGE); end
    n_tests++; if ({O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT, O_INSUFFICIENT, O_COIN_RETURN} !== 5'b0) begin n_fail++; $display("FAIL midreset_pulses: pulses=%b expected 00000", {O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT, O_INSUFFICIENT, O_COIN_RETURN}); end
    I_RESET = 1'b0;
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b0 || O_INSUFFICIENT !== 1'b0) begin n_fail++; $display("FAIL midreset_no_pulse: valid=%b insuff=%b expected 0 0", O_CHANGE_VALID, O_INSUFFICIENT); end
    insert(16'd100);
    select_item(4'b0100, 4'b0100);
    n_tests++; if (O_PRICE !== 16'd100) begin n_fail++; $display("FAIL midreset_price_default: O_PRICE=%0d expected 100", O_PRICE); end
    cyc();
    cyc();
    n_tests++; if (O_SUCCESS !== 1'b1 || O_SEL !== 4'd10) begin n_fail++; $display("FAIL midreset_vend: success=%b sel=%0d expected 1 10", O_SUCCESS, O_SEL); end
    cyc();
    n_tests++; if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd0) begin n_fail++; $display("FAIL midreset_change: valid=%b change=%0d expected 1 0", O_CHANGE_VALID, O_CHANGE); end
  endtask

  initial begin
    I_RESET      = 1'b1;
    I_COIN_VALID = 1'b0;
    I_COIN_VALUE = '0;
    I_ROW        = '0;
    I_COL        = '0;
    I_CANCEL     = 1'b0;
    I_ITEM_ADDR  = '0;
    I_PRICE_WE   = 1'b0;
    I_PRICE_DATA = '0;
    I_RESTOCK    = 1'b0;

    test_reset();
    test_exact_credit();
    test_insufficient();
    test_back_to_back();
    test_sold_out();
    test_cancel_coins();
    test_timeout();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
